fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register and the IF/ID pipeline register, and is the responder to the load-use stall controls (`pc_write`, `if_id_write`) and to the EX-stage branch flush/redirect. Issues single-outstanding requests to instruction memory over a req/ready/rvalid handshake and buffers a returned instruction while the pipeline is stalled. Feeds the decode stage and the hazard unit's rs1/rs2 extraction.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `XLEN`, 32: address/instruction width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_write` in 1: 0 = freeze PC (stall).
- `if_id_write` in 1: 0 = hold IF/ID contents.
- `flush` in 1: squash IF/ID (taken branch/jump in EX).
- `redirect_valid` in 1: load new PC this cycle.
- `redirect_pc` in XLEN: redirect target.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch address.
- `imem_ready` in 1: memory accepts request this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in XLEN: fetched instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out XLEN: PC of IF/ID instruction.
- `if_id_instr` out XLEN: IF/ID instruction (NOP when invalid).
- `fetch_misaligned` out 1: see Configuration.

## Operation
- FSM states: REQ (drive `imem_req`), WAIT (accepted, awaiting `imem_rvalid`), HOLD (response captured in hold buffer, IF/ID write blocked).
- `imem_req` = (state==REQ); `imem_addr` = `pc_q`. REQ->WAIT on `imem_req && imem_ready`; fetch PC latched.
- WAIT + `imem_rvalid`: if drop flag set -> discard, clear drop, ->REQ. Else if `if_id_write` -> load IF/ID {valid=1, pc, rdata}, ->REQ; else -> store in hold buffer, ->HOLD.
- HOLD + `if_id_write` -> load IF/ID from buffer, ->REQ.
- `pc_q` <= `pc_q`+4 only when an instruction is loaded into IF/ID and `pc_write`=1; wraps modulo 2^XLEN.
- `if_id_write`=1 with no instruction available -> IF/ID loads bubble (valid=0, instr=32'h0000_0013, pc unchanged).
- `imem_rvalid` outside WAIT is ignored.
- Priority: `flush` > `if_id_write` for IF/ID (flush forces valid=0, NOP). `redirect_valid` > `pc_write` for PC: `pc_q`<=`redirect_pc`; in WAIT set drop flag, stay WAIT; in HOLD discard buffer, ->REQ; in REQ stay REQ with new address (a same-cycle accept of the old address sets drop).
- Max one outstanding request at all times.

## Timing
- Reset (async assert): state=REQ, `pc_q`=RESET_PC, drop=0, `if_id_valid`=0, `if_id_instr`=32'h0000_0013, `if_id_pc`=0, `fetch_misaligned`=0; `imem_req`=1 from first cycle after deassert. Reset mid-transaction abandons it; late `rvalid` ignored.
- Best case (ready=1, rvalid 1 cycle after accept): request cycle N, IF/ID valid at N+2; sustained throughput one instruction per 2 cycles.
- Redirect at cycle N (state REQ) -> `imem_addr`=`redirect_pc` at N+1.
- All outputs registered except `imem_req`/`imem_addr` (decoded from state/`pc_q`).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`!=0 sets sticky `fetch_misaligned`=1 (cleared only by reset), PC loads `redirect_pc` with bits [1:0] forced to 0.
- Undefined: no check; `fetch_misaligned` tied 0; `redirect_pc` loaded unmodified.

## Structure
- `pipeline_pkg`: `NOP_INSTR` (32'h0000_0013), `fetch_state_t` enum {REQ, WAIT, HOLD}, `XLEN` default.
- Single module; hold buffer and FSM inline, no sub-module.

## Test plan
- Reset, ready=1, rvalid 1-cycle latency, memory word = addr -> IF/ID sees pc 0x0,0x4,0x8 with instr 0x0,0x4,0x8, valid every other cycle.
- Stall (`pc_write`=`if_id_write`=0) 3 cycles while rvalid arrives -> state HOLD, IF/ID unchanged; on release IF/ID loads buffered instr, next `imem_addr`=pc+4.
- `redirect_valid`=1, `redirect_pc`=0x100, `flush`=1 in WAIT -> old response dropped, IF/ID valid=0 NOP, next request addr 0x100, next valid pc 0x100.
- `imem_ready`=0 for 4 cycles -> `imem_req` held, `imem_addr` stable, IF/ID bubbles when `if_id_write`=1.
- `rst_n` pulsed low in WAIT, rvalid arrives after release -> response ignored, `imem_addr`=RESET_PC, `if_id_valid`=0.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 -> `fetch_misaligned`=1 sticky, `imem_addr`=0x100.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants for the RV32I core
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, single-outstanding imem fetch, hold buffer, IF/ID register
// Optional FETCH_MISALIGN_CHECK_EN: sticky misaligned-redirect flag and word-aligned redirect target.
module fetch_stage #(
    parameter int              XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            fetch_misaligned
);
    import pipeline_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] hold_instr_q;
    logic            drop_q, drop_d;
    logic            hold_capture;
    logic            rsp_live, buf_live, avail, load;
    logic [XLEN-1:0] avail_instr;
    logic [XLEN-1:0] redirect_tgt;

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    // A response is usable only if it was not orphaned by an earlier or same-cycle redirect.
    assign rsp_live    = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect_valid;
    assign buf_live    = (state_q == HOLD) && !redirect_valid;
    assign avail       = rsp_live || buf_live;
    assign avail_instr = buf_live ? hold_instr_q : imem_rdata;
    assign load        = avail && if_id_write && !flush;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`else
    assign redirect_tgt = redirect_pc;
`endif

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        hold_capture = 1'b0;
        case (state_q)
            REQ: begin
                if (imem_ready) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (rsp_live && !load) begin
                        state_d      = HOLD;
                        hold_capture = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || load) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end else if (load && pc_write) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            fetch_pc_q   <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (imem_req && imem_ready) begin
                fetch_pc_q <= pc_q;
            end
            if (hold_capture) begin
                hold_instr_q <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= XLEN'(NOP_INSTR);
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= XLEN'(NOP_INSTR);
        end else if (if_id_write) begin
            if (load) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= fetch_pc_q;
                if_id_instr <= avail_instr;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= XLEN'(NOP_INSTR);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misaligned <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_misaligned <= 1'b1;
        end
    end
`else
    assign fetch_misaligned = 1'b0;
`endif

endmodule
